// File: rtl/pll_lock_ctrl.sv
// PLL bring-up and lock supervisor: pulses the PLL reset, counts synchronized toggle
// edges over fixed reference windows, and gates the system reset on a verified frequency.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned EXP_MIN       = 76,
  parameter int unsigned EXP_MAX       = 84,
  parameter int unsigned GOOD_WINDOWS  = 2,
  parameter int unsigned MAX_RETRY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_tog,
  output logic        pll_reset,
  output logic        sys_rst_n,
  output logic        locked,
  output logic        fail,
  output logic [2:0]  retry_cnt,
  output logic [15:0] meas_cnt,
  output logic        meas_valid
);

  localparam int unsigned WW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned PMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int unsigned GW   = $clog2(GOOD_WINDOWS + 1);

  localparam logic [2:0] S_RST     = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] phase;
  logic [WW-1:0] win;
  logic [15:0]   edge_cnt;
  logic [GW-1:0] good;
  logic          sync1, sync2, sync3;

  logic          rise;
  logic          win_last;
  logic          in_range;
  logic [15:0]   cnt_sum;

  always_comb begin
    rise     = sync2 & ~sync3;
    cnt_sum  = (edge_cnt == 16'hFFFF) ? 16'hFFFF : edge_cnt + {15'd0, rise};
    in_range = (cnt_sum >= 16'(EXP_MIN)) && (cnt_sum <= 16'(EXP_MAX));
    win_last = (win == WW'(WINDOW - 1));
  end

  // Status outputs are registered from the current state, so they follow a
  // transition by one cycle (locked rises the cycle after the final good window).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RST;
      phase      <= '0;
      win        <= '0;
      edge_cnt   <= '0;
      good       <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= '0;
      meas_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      sync1      <= pll_tog;
      sync2      <= sync1;
      sync3      <= sync2;
      meas_valid <= 1'b0;
      pll_reset  <= (state == S_RST) || (state == S_FAIL);
      locked     <= (state == S_RUN);
      sys_rst_n  <= (state == S_RUN);
      fail       <= (state == S_FAIL);

      case (state)
        S_RST: begin
          win      <= '0;
          edge_cnt <= '0;
          if (phase == PW'(RST_CYCLES - 1)) begin
            phase <= '0;
            state <= S_SETTLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_SETTLE: begin
          win      <= '0;
          edge_cnt <= '0;
          if (phase == PW'(SETTLE_CYCLES - 1)) begin
            phase <= '0;
            state <= S_MEASURE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_MEASURE, S_RUN: begin
          if (win_last) begin
            win        <= '0;
            edge_cnt   <= '0;
            meas_cnt   <= cnt_sum;
            meas_valid <= 1'b1;
            if (in_range) begin
              if (state == S_MEASURE) begin
                if (good == GW'(GOOD_WINDOWS - 1)) begin
                  good      <= '0;
                  retry_cnt <= '0;
                  state     <= S_RUN;
                end else begin
                  good <= good + GW'(1);
                end
              end
            end else if (state == S_RUN) begin
              // Losing lock starts a fresh acquisition with a full retry budget.
              retry_cnt <= '0;
              good      <= '0;
              state     <= S_RST;
            end else if (retry_cnt == 3'(MAX_RETRY)) begin
              state <= S_FAIL;
            end else begin
              retry_cnt <= retry_cnt + 3'd1;
              good      <= '0;
              state     <= S_RST;
            end
          end else begin
            win      <= win + WW'(1);
            edge_cnt <= cnt_sum;
          end
        end
        S_FAIL: begin
          win      <= '0;
          edge_cnt <= '0;
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl; the toggle generator produces exactly N rising
// edges in any 1024-cycle span, so window counts are known exactly.
module tb_pll_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_tog = 1'b0;
  logic        pll_reset, sys_rst_n, locked, fail, meas_valid;
  logic [2:0]  retry_cnt;
  logic [15:0] meas_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int unsigned rst_hi = 0;
  int unsigned tog_n = 0;
  int unsigned acc = 0;

  pll_lock_ctrl #(
    .RST_CYCLES(16), .SETTLE_CYCLES(256), .WINDOW(1024), .EXP_MIN(76),
    .EXP_MAX(84), .GOOD_WINDOWS(2), .MAX_RETRY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_tog(pll_tog), .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n), .locked(locked), .fail(fail), .retry_cnt(retry_cnt),
    .meas_cnt(meas_cnt), .meas_valid(meas_valid)
  );

  always #5 clk = ~clk;

  // 2N toggles per 1024 clocks: phase accumulator wraps exactly 2N times per 1024 steps.
  always @(negedge clk) begin
    acc = acc + 2 * tog_n;
    if (acc >= 1024) begin
      acc = acc - 1024;
      pll_tog = ~pll_tog;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pll_reset) rst_hi++;
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) step();
  endtask

  task automatic start_acq(input int unsigned n);
    tog_n = n;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n  = 1'b1;
    cyc    = 0;
    rst_hi = 0;
  endtask

  int unsigned bnd_n   [4] = '{75, 76, 84, 85};
  logic        bnd_bad [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_pll_reset", 32'(pll_reset), 1);
    check("rst_sys_rst_n", 32'(sys_rst_n), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_meas_cnt", 32'(meas_cnt), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);

    // nominal acquisition
    start_acq(80);
    run_to(16);   check("nom_pll_reset_hi", 32'(pll_reset), 1);
    run_to(17);   check("nom_pll_reset_lo", 32'(pll_reset), 0);
    run_to(1295); check("nom_valid_early", 32'(meas_valid), 0);
    run_to(1296); check("nom_valid1", 32'(meas_valid), 1);
                  check("nom_cnt1", 32'(meas_cnt), 80);
    run_to(2320); check("nom_cnt2", 32'(meas_cnt), 80);
                  check("nom_locked_early", 32'(locked), 0);
    run_to(2321); check("nom_locked", 32'(locked), 1);
                  check("nom_sys_rst_n", 32'(sys_rst_n), 1);
                  check("nom_retry", 32'(retry_cnt), 0);

    // loss of lock
    tog_n = 0;
    run_to(3344); check("loss_valid", 32'(meas_valid), 1);
                  check("loss_cnt_low", 32'(meas_cnt < 16'd76), 1);
                  check("loss_locked_still", 32'(locked), 1);
    run_to(3345); check("loss_locked", 32'(locked), 0);
                  check("loss_sys_rst_n", 32'(sys_rst_n), 0);
                  check("loss_pll_reset", 32'(pll_reset), 1);
                  check("loss_retry", 32'(retry_cnt), 0);
    tog_n = 80;
    run_to(4640); check("relock_cnt", 32'(meas_cnt), 80);
    run_to(5664); check("relock_early", 32'(locked), 0);
    run_to(5665); check("relock_locked", 32'(locked), 1);

    // wrong frequency, then nominal
    start_acq(128);
    run_to(1296); check("wf_cnt", 32'(meas_cnt), 128);
    run_to(1297); check("wf_retry", 32'(retry_cnt), 1);
                  check("wf_pll_reset", 32'(pll_reset), 1);
    tog_n = 80;
    run_to(2592); check("wf_cnt2", 32'(meas_cnt), 80);
    run_to(3616); check("wf_locked_early", 32'(locked), 0);
    run_to(3617); check("wf_locked", 32'(locked), 1);
                  check("wf_retry_clr", 32'(retry_cnt), 0);

    // range boundaries, plus a reset pulse while measuring
    for (int i = 0; i < 4; i++) begin
      start_acq(bnd_n[i]);
      run_to(1296); check("bnd_cnt", 32'(meas_cnt), 32'(bnd_n[i]));
      run_to(1297); check("bnd_retry", 32'(retry_cnt), 32'(bnd_bad[i]));
                    check("bnd_pll_reset", 32'(pll_reset), 32'(bnd_bad[i]));
      if (i == 1) begin
        rst_n = 1'b0;
        step();
        check("mrst_pll_reset", 32'(pll_reset), 1);
        check("mrst_meas_cnt", 32'(meas_cnt), 0);
        check("mrst_locked", 32'(locked), 0);
        check("mrst_sys_rst_n", 32'(sys_rst_n), 0);
        rst_n = 1'b1;
      end
    end

    // dead PLL
    start_acq(0);
    for (int k = 1; k <= 5; k++) begin
      run_to(1296 * k);
      check("dead_valid", 32'(meas_valid), 1);
      check("dead_cnt", 32'(meas_cnt), 0);
      check("dead_retry", 32'(retry_cnt), (k < 5) ? k : 4);
    end
    check("dead_fail_early", 32'(fail), 0);
    check("dead_reset_cycles", rst_hi, 80);
    run_to(6481); check("dead_fail", 32'(fail), 1);
                  check("dead_pll_reset", 32'(pll_reset), 1);
                  check("dead_locked", 32'(locked), 0);
    run_to(6600); check("dead_fail_sticky", 32'(fail), 1);
                  check("dead_pll_reset_stuck", 32'(pll_reset), 1);
                  check("dead_retry_hold", 32'(retry_cnt), 4);

    // reset out of FAIL
    rst_n = 1'b0;
    step();
    check("frst_fail", 32'(fail), 0);
    check("frst_retry", 32'(retry_cnt), 0);
    check("frst_pll_reset", 32'(pll_reset), 1);
    rst_n = 1'b1;
    step();
    check("frst_fail_after", 32'(fail), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
